// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and event bundle
// for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;
  localparam int         EVENT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO with
// sticky overflow flag.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_ready,
  input  logic             i_ovf_clr,
  output logic             o_rd_valid,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_ovf;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && i_rd_ready;
  // a pop frees the slot the concurrent push lands in
  assign w_push  = i_wr_en && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)
        r_rptr <= r_rptr + PTR_ONE;
      if (i_wr_en && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (i_ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  assign o_rd_valid = !w_empty;
  assign o_rd_data  = w_empty ? '0
                    : r_mem[r_rptr[AW-1:0]];
  assign o_overflow = r_ovf;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: line filtering, frame FSM,
// E0/F0 prefix decoder and buffered key events.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_US  = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kclk,
  input  logic        kdata,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [7:0]  ev_code,
  output logic        ev_ext,
  output logic        ev_rel,
  output logic [31:0] keycode_hist,
  output logic [7:0]  err_count,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0] F_MAX =
    FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] F_ONE = FW'(1);
  localparam int TO_CYC =
    CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_CYC - 1);
  localparam logic [TW-1:0] TO_ONE = TW'(1);

  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_filt;
  logic [FW-1:0] r_fcnt [2];
  logic          r_kclk_d;
  logic          w_fall;
  logic          w_bit;

  ps2_state_t    r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tocnt;
  logic          r_byte_vld;
  logic [7:0]    r_byte;
  logic [7:0]    r_err;

  logic          r_ext;
  logic          r_rel;
  logic [31:0]   r_hist;
  logic          r_push;
  ps2_event_t    r_push_ev;
  logic [EVENT_W-1:0] w_head_raw;
  ps2_event_t    w_head;

  // index 0 carries kclk, index 1 carries kdata
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1     <= 2'b11;
      r_s2     <= 2'b11;
      r_filt   <= 2'b11;
      r_fcnt   <= '{default: '0};
      r_kclk_d <= 1'b1;
    end else begin
      r_s1     <= {kdata, kclk};
      r_s2     <= r_s1;
      r_kclk_d <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == F_MAX) begin
          r_filt[i] <= r_s2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + F_ONE;
        end
      end
    end
  end

  assign w_fall = r_kclk_d && !r_filt[0];
  assign w_bit  = r_filt[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tocnt    <= '0;
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
      r_err      <= '0;
    end else begin
      r_byte_vld <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_tocnt <= '0;
        if (w_fall && !w_bit) begin
          r_state  <= ST_DATA;
          r_bitcnt <= '0;
        end
      end else if (w_fall) begin
        r_tocnt <= '0;
        unique case (r_state)
          ST_DATA: begin
            r_shift  <= {w_bit, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7)
              r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_par   <= w_bit;
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (w_bit && ^{r_shift, r_par}) begin
              r_byte_vld <= 1'b1;
              r_byte     <= r_shift;
            end else begin
              r_err <= sat_inc8(r_err);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (r_tocnt == TO_MAX) begin
        r_state <= ST_IDLE;
        r_tocnt <= '0;
        r_err   <= sat_inc8(r_err);
      end else begin
        r_tocnt <= r_tocnt + TO_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ext     <= 1'b0;
      r_rel     <= 1'b0;
      r_hist    <= '0;
      r_push    <= 1'b0;
      r_push_ev <= '0;
    end else begin
      r_push <= 1'b0;
      if (r_byte_vld) begin
        r_hist <= {r_hist[23:0], r_byte};
        unique case (1'b1)
          (r_byte == PS2_EXT): r_ext <= 1'b1;
          (r_byte == PS2_REL): r_rel <= 1'b1;
          default: begin
            r_push    <= 1'b1;
            r_push_ev <= '{ext: r_ext,
                           rel: r_rel,
                           code: r_byte};
            r_ext     <= 1'b0;
            r_rel     <= 1'b0;
          end
        endcase
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (r_push),
    .i_wr_data  (r_push_ev),
    .i_rd_ready (ev_ready),
    .i_ovf_clr  (ovf_clr),
    .o_rd_valid (ev_valid),
    .o_rd_data  (w_head_raw),
    .o_overflow (overflow)
  );

  assign w_head       = ps2_event_t'(w_head_raw);
  assign ev_code      = w_head.code;
  assign ev_ext       = w_head.ext;
  assign ev_rel       = w_head.rel;
  assign keycode_hist = r_hist;
  assign err_count    = r_err;

endmodule
